// File: rtl/perceptron_neuron.sv
// rtl/perceptron_neuron.sv - sequential Q32.32 perceptron: MAC over N pairs, bias, activation
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin an evaluation (honoured only in IDLE)
//   bias, act_sel       bias and activation code, latched on accepted start
//                       (0=Step, 1=Sigmoid, 2=Tanh, 3=ReLU)
//   in_valid/in_ready   input pair handshake, in_x/in_w signed Q32.32
//   out_valid/out_ready result handshake, out_y signed Q32.32
//   busy                high whenever the block is not IDLE
module perceptron_neuron #(
  parameter int N_INPUTS  = 4,
  parameter int FRAC_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] bias,
  input  logic [1:0]  act_sel,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_x,
  input  logic [63:0] in_w,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_y,
  output logic        busy
);

  localparam int CW = $clog2(N_INPUTS + 1);

  localparam logic signed [63:0] ONE     = 64'sh0000_0001_0000_0000;
  localparam logic signed [63:0] NEG_ONE = 64'shFFFF_FFFF_0000_0000;
  localparam logic signed [63:0] TWO     = 64'sh0000_0002_0000_0000;
  localparam logic signed [63:0] NEG_TWO = 64'shFFFF_FFFE_0000_0000;
  localparam logic signed [63:0] HALF    = 64'sh0000_0000_8000_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    FINISH = 3'd2,
    ACT    = 3'd3,
    OUT    = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic signed [63:0] acc;
  logic signed [63:0] prod;
  logic               prod_v;
  logic [CW-1:0]      count;
  logic [1:0]         act_q;
  logic               accept;
  logic               last_pair;
  logic signed [127:0] prod_full;
  logic signed [63:0] prod_next;
  logic signed [63:0] act_y;
  logic               unused_prod_bits;

  assign in_ready  = (state == ACCUM);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign last_pair = (count == CW'(N_INPUTS - 1));

  // Full 128-bit signed product; keeping bits [FRAC_BITS +: 64] is an
  // arithmetic shift right that floors toward -inf and wraps on overflow.
  assign prod_full        = $signed(in_x) * $signed(in_w);
  assign prod_next        = prod_full[FRAC_BITS +: 64];
  assign unused_prod_bits = ^{prod_full[127:FRAC_BITS+64], prod_full[FRAC_BITS-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (accept && last_pair) state_next = FINISH;
      FINISH:  state_next = ACT;
      ACT:     state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Hard piecewise-linear activations on the final accumulator.
  always_comb begin
    act_y = acc;
    case (act_q)
      2'd0: act_y = (acc >= 64'sd0) ? ONE : 64'sd0;
      2'd1: begin
        if (acc >= TWO)          act_y = ONE;
        else if (acc <= NEG_TWO) act_y = 64'sd0;
        else                     act_y = (acc >>> 2) + HALF;
      end
      2'd2: begin
        if (acc >= ONE)          act_y = ONE;
        else if (acc <= NEG_ONE) act_y = NEG_ONE;
        else                     act_y = acc;
      end
      default: act_y = (acc < 64'sd0) ? 64'sd0 : acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      prod      <= '0;
      prod_v    <= 1'b0;
      count     <= '0;
      act_q     <= 2'd0;
      out_y     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= $signed(bias);
            act_q  <= act_sel;
            count  <= '0;
            prod_v <= 1'b0;
          end
        end
        ACCUM: begin
          // The product registered on the previous accept is folded in here,
          // one edge behind the multiply.
          if (accept) begin
            prod   <= prod_next;
            prod_v <= 1'b1;
            count  <= count + CW'(1);
          end else begin
            prod_v <= 1'b0;
          end
          if (prod_v) acc <= acc + prod;
        end
        FINISH: begin
          if (prod_v) acc <= acc + prod;
          prod_v <= 1'b0;
        end
        ACT: begin
          out_y     <= act_y;
          out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_neuron.sv
// tb/tb_perceptron_neuron.sv - scoreboard bench for perceptron_neuron
module tb_perceptron_neuron;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] bias = '0;
  logic [1:0]  act_sel = 2'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_x = '0;
  logic [63:0] in_w = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_y;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  perceptron_neuron #(.N_INPUTS(4), .FRAC_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .act_sel(act_sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] q(input real r);
    return 64'(longint'(r * 4294967296.0));
  endfunction

  // Reference: products floored to 2^-32, summed with the bias, then activated.
  function automatic logic [63:0] model(input real b, input int act, input real xs[4], input real ws[4]);
    longint a;
    longint one;
    one = 64'sh1_0000_0000;
    a = longint'(b * 4294967296.0);
    for (int i = 0; i < 4; i++) a += longint'($floor(xs[i] * ws[i] * 4294967296.0));
    case (act)
      0: return (a >= 0) ? one : 64'd0;
      1: return (a >= 2 * one) ? one : (a <= -2 * one) ? 64'd0 : 64'((a >>> 2) + one / 2);
      2: return (a >= one) ? one : (a <= -one) ? 64'(-one) : 64'(a);
      default: return (a < 0) ? 64'd0 : 64'(a);
    endcase
  endfunction

  task automatic run_txn(input string tag, input real b, input int act,
                         input real xs[4], input real ws[4],
                         input logic [15:0] vpat, input int hold, input bit start_in_out);
    int idx;
    int cyc;
    logic [63:0] held;
    logic [63:0] exp;
    @(negedge clk);
    start   = 1'b1;
    bias    = q(b);
    act_sel = 2'(act);
    sb.push_back(model(b, act, xs, ws));
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 40) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = (cyc < 16) ? vpat[cyc] : 1'b1;
      in_x     = q(xs[idx]);
      in_w     = q(ws[idx]);
      @(posedge clk);
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    check({tag, " pairs_accepted"}, 64'(idx), 64'd4);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " in_ready_finish"}, 64'(in_ready), 64'd0);
    @(negedge clk);
    check({tag, " out_valid_e1"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check({tag, " out_valid_e2"}, 64'(out_valid), 64'd1);
    held = out_y;
    for (int k = 0; k < hold; k++) begin
      start = start_in_out && (k == 1);
      @(negedge clk);
      check({tag, " hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, " hold_y"}, out_y, held);
      check({tag, " hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    start = start_in_out;
    exp = sb.pop_front();
    check({tag, " out_y"}, out_y, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    check({tag, " after_valid"}, 64'(out_valid), 64'd0);
    check({tag, " after_busy"}, 64'(busy), 64'd0);
  endtask

  real xa[4];
  real wa[4];
  real x1[4];
  real w1[4];
  real z[4];

  initial begin
    x1 = '{1.0, 2.0, -1.0, 0.5};
    w1 = '{0.5, 0.25, 1.0, 2.0};
    z  = '{0.0, 0.0, 0.0, 0.0};
    xa = '{1.0, 0.0, 0.0, 0.0};
    wa = '{1.0, 0.0, 0.0, 0.0};

    repeat (2) @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset out_y", out_y, 64'd0);
    rst_n = 1'b1;

    run_txn("s1 relu", 0.5, 3, x1, w1, 16'hFFFF, 0, 1'b0);
    run_txn("s2 step", 0.5, 0, x1, w1, 16'hFFFF, 0, 1'b0);
    run_txn("s2 step_neg", -3.0, 0, x1, w1, 16'hFFFF, 0, 1'b0);
    run_txn("s3 sig_1", 0.0, 1, xa, wa, 16'hFFFF, 0, 1'b0);
    run_txn("s3 sig_3", 2.0, 1, xa, wa, 16'hFFFF, 0, 1'b0);
    run_txn("s3 sig_m3", -4.0, 1, xa, wa, 16'hFFFF, 0, 1'b0);
    run_txn("sig_eq2", 1.0, 1, xa, wa, 16'hFFFF, 0, 1'b0);
    run_txn("sig_eqm2", -3.0, 1, xa, wa, 16'hFFFF, 0, 1'b0);
    run_txn("s4 tanh_m25", -3.5, 2, xa, wa, 16'hFFFF, 0, 1'b0);
    run_txn("s4 tanh_05", -0.5, 2, xa, wa, 16'hFFFF, 0, 1'b0);
    run_txn("tanh_eq1", 0.0, 2, xa, wa, 16'hFFFF, 0, 1'b0);
    run_txn("tanh_eqm1", -2.0, 2, xa, wa, 16'hFFFF, 0, 1'b0);
    xa = '{-0.5, 0.0, 0.0, 0.0};
    wa = '{3.0, 0.0, 0.0, 0.0};
    run_txn("s4 neg_prod", 0.0, 2, xa, wa, 16'hFFFF, 0, 1'b0);
    xa = '{1.0 / 4294967296.0, 0.0, 0.0, 0.0};
    wa = '{-0.5, 0.0, 0.0, 0.0};
    run_txn("floor_lsb", 0.0, 2, xa, wa, 16'hFFFF, 0, 1'b0);
    run_txn("relu_zero", 0.0, 3, z, z, 16'hFFFF, 0, 1'b0);

    // 1,0,0,1,1,0,1 on in_valid (LSB first), 5 held cycles, stray start in OUT.
    run_txn("s5 backpressure", 0.5, 3, x1, w1, 16'b1111_1111_1101_1001, 5, 1'b1);

    // Asynchronous reset after two accepted pairs.
    @(negedge clk);
    start   = 1'b1;
    bias    = q(0.5);
    act_sel = 2'd3;
    sb.push_back(model(0.5, 3, x1, w1));
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_x     = q(x1[0]);
    in_w     = q(w1[0]);
    @(negedge clk);
    in_x = q(x1[1]);
    in_w = q(w1[1]);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6 rst busy", 64'(busy), 64'd0);
    check("s6 rst in_ready", 64'(in_ready), 64'd0);
    check("s6 rst out_valid", 64'(out_valid), 64'd0);
    check("s6 rst out_y", out_y, 64'd0);
    sb.delete();
    @(negedge clk);
    in_valid = 1'b0;
    check("s6 rst idle_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    run_txn("s6 fresh", 0.5, 3, x1, w1, 16'hFFFF, 0, 1'b0);

    check("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/perceptron_neuron.md
Name: perceptron_neuron

Overview:
Sequential single-neuron compute stage for the MLP datapath. It sits directly upstream of the layer output buffer and consumes Q32.32 signed fixed-point operands, in the same format as the FixedPoint package (sfp, frac_bits=32). It streams N input/weight pairs through a registered multiply-accumulate, adds a bias, and applies the activation selected by a Common::act_func code. Sigmoid and tanh use hard piecewise-linear forms so the block is synthesizable.

Parameters:
N_INPUTS, 4, number of input/weight pairs per neuron evaluation (>=1)
FRAC_BITS, 32, fractional bits of the Q format (fixed at 32; operands are 64-bit)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin an evaluation; sampled only in IDLE
bias  in  64  signed Q32.32 bias, latched on accepted start
act_sel  in  2  0=Step, 1=Sigmoid, 2=Tanh, 3=ReLU (act_func order); latched on start
in_valid  in  1  input pair valid
in_ready  out  1  block accepts pair
in_x  in  64  signed Q32.32 input
in_w  in  64  signed Q32.32 weight
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_y  out  64  signed Q32.32 activated output
busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-low. While rst_n=0, every register clears: state=IDLE, acc=0, prod=0, count=0, out_y=0, out_valid=0, in_ready=0, busy=0. Reset mid-operation discards the transaction entirely.
- FSM states: IDLE, ACCUM, FINISH, ACT, OUT.
- IDLE: when start=1, latch bias into acc, latch act_sel, set count=0, prod_v=0, and go to ACCUM. start is ignored in all other states.
- ACCUM:
  - in_ready=1. A pair is accepted on any edge where in_valid && in_ready.
  - On accept: prod <= (in_x*in_w) as a 128-bit signed product, arithmetic-shifted right by 32, low 64 bits kept. This truncates toward -inf and wraps on overflow, identical to sfp_mul. Also set prod_v <= 1 and count <= count+1.
  - On a non-accept edge: prod_v <= 0.
  - On every edge where prod_v=1: acc <= acc + prod, 64-bit wrapping add with no saturation.
  - Gaps in in_valid are allowed at any point.
  - When the accepted pair is the N_INPUTS-th, the next state is FINISH.
- FINISH: in_ready=0. Add the final pending prod into acc, then go to ACT.
- ACT: compute f(acc) and register it into out_y, set out_valid=1, go to OUT.
  - Step: acc>=0 -> 0x1_0000_0000, else 0.
  - ReLU: acc<0 -> 0, else acc.
  - Sigmoid: acc>=2.0 -> ONE; acc<=-2.0 -> 0; otherwise (acc>>>2)+0x8000_0000.
  - Tanh: acc>=1.0 -> ONE; acc<=-1.0 -> 0xFFFF_FFFF_0000_0000; otherwise acc.
- OUT: out_valid=1 and out_y are held stable until out_ready=1. On that edge out_valid <= 0 and the state returns to IDLE. A start arriving on the same edge is ignored; it must be reissued once the block is in IDLE.
- Latency: for the accept edge E of the last pair, acc is final after E+1 and out_valid rises after E+2. With no input gaps, start-to-out_valid is N_INPUTS+3 cycles.
- Throughput: at most one pair per cycle. in_ready is combinational from state only, never from in_valid.
- out_y keeps its last value after the handshake and is only valid while out_valid=1.

Test Plan:
1. N=4, bias=0x8000_0000 (0.5), x={1.0,2.0,-1.0,0.5}, w={0.5,0.25,1.0,2.0}, act=ReLU, pairs back-to-back -> sum=1.5, out_y=0x0000_0001_8000_0000, out_valid 2 cycles after the 4th accept edge.
2. Same data with act=Step -> out_y=0x1_0000_0000. With bias=-3.0 (0xFFFF_FFFD_0000_0000), the sum is -2.0 -> out_y=0.
3. act=Sigmoid, inputs giving sum=1.0 -> out_y=0xC000_0000. Sum=3.0 -> 0x1_0000_0000. Sum=-3.0 -> 0.
4. act=Tanh: sum=-2.5 -> 0xFFFF_FFFF_0000_0000; sum=0.5 -> 0x8000_0000. Negative product check: x=-0.5 (0xFFFF_FFFF_8000_0000), w=3.0, bias=0 -> acc=-1.5 exactly, Tanh -> 0xFFFF_FFFF_0000_0000.
5. Backpressure: in_valid toggles 1,0,0,1,1,0,1 and out_ready is held low for 5 cycles in OUT. out_y stays constant, in_ready=0 throughout OUT, and a start pulse during OUT is ignored. The result equals the gap-free run.
6. Assert rst_n=0 asynchronously after 2 pairs have been accepted. All outputs go to 0 immediately, busy=0, and the FSM is in IDLE. A fresh scenario-1 transaction afterwards yields 0x1_8000_0000.
